// File: rtl/dorow_job_ctrl_if.sv
// Host memory-mapped request/response bus for the DoRow job controller.
// The host drives the master side; the controller is the slave.
interface dorow_job_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic                valid;
    logic [3:0]          addr;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   wdata;
    logic                ready;
    logic [DATA_W-1:0]   rdata;

    modport master (output valid, addr, wstrb, wdata, input ready, rdata);
    modport slave (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/dorow_job_ctrl.sv
// Job sequencer for the four-lane DoRow mix datapath: holds delay amounts and job length,
// pulses run, admits LEN beats and tracks them through the fixed-latency pipeline.
module dorow_job_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned LEN_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    dorow_job_ctrl_if.slave   bus,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              m_valid,
    output logic              run,
    output logic [47:0]       amounts,
    output logic              done_irq
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StFeed  = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               run_q, run_d;
    logic               s_ready_q, s_ready_d;
    logic               done_irq_q, done_irq_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   outcnt_q, outcnt_d;
    logic [47:0]        amt_q, amt_d;
    logic [LATENCY-1:0] sr_q, sr_d;
    logic               ready_q, ready_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic              wr, busy, start, abort, accept;
    logic [DATA_W-1:0] rd;
    logic              unused_wdata;

    assign unused_wdata = ^bus.wdata;

    assign wr     = bus.valid && (|bus.wstrb);
    assign busy   = (state_q != StIdle);
    assign abort  = wr && (bus.addr == 4'd0) && bus.wdata[1];
    assign start  = wr && (bus.addr == 4'd0) && bus.wdata[0] && !bus.wdata[1];
    assign accept = s_valid && s_ready_q;

    always_comb begin
        rd = '0;
        case (bus.addr)
            4'd1: rd[3:0] = {state_q, done_q, busy};
            4'd2: rd[LEN_W-1:0] = len_q;
            4'd3: for (int k = 0; k < 4; k++) rd[8*k +: 6] = amt_q[6*k +: 6];
            4'd4: for (int k = 0; k < 4; k++) rd[8*k +: 6] = amt_q[24 + 6*k +: 6];
            4'd5: rd[LEN_W-1:0] = outcnt_q;
            default: rd = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b0;
        s_ready_d  = s_ready_q;
        done_irq_d = 1'b0;
        done_d     = done_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        outcnt_d   = outcnt_q;
        amt_d      = amt_q;
        sr_d       = sr_q << 1;
        sr_d[0]    = accept;
        ready_d    = bus.valid;
        rdata_d    = (bus.valid && !wr) ? rd : '0;

        if (m_valid && (outcnt_q != '1)) begin
            outcnt_d = outcnt_q + LEN_W'(1);
        end

        // Configuration is frozen while a job is in flight.
        if (wr && !busy) begin
            case (bus.addr)
                4'd2: len_d = bus.wdata[LEN_W-1:0];
                4'd3: for (int k = 0; k < 4; k++) amt_d[6*k +: 6] = bus.wdata[8*k +: 6];
                4'd4: for (int k = 0; k < 4; k++) amt_d[24 + 6*k +: 6] = bus.wdata[8*k +: 6];
                default: ;
            endcase
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_q != '0) begin
                        done_d   = 1'b0;
                        outcnt_d = '0;
                        cnt_d    = len_q;
                        run_d    = 1'b1;
                        state_d  = StArm;
                    end else begin
                        done_d     = 1'b1;
                        done_irq_d = 1'b1;
                    end
                end
            end
            StArm: begin
                state_d   = StFeed;
                s_ready_d = 1'b1;
            end
            StFeed: begin
                if (accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d   = StDrain;
                        s_ready_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                // Finish on the edge that shifts the final tracked beat out.
                if (sr_d == '0) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    done_irq_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d    = StIdle;
            run_d      = 1'b0;
            s_ready_d  = 1'b0;
            done_irq_d = 1'b0;
            done_d     = done_q;
            sr_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            run_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            done_irq_q <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            outcnt_q   <= '0;
            amt_q      <= '0;
            sr_q       <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            s_ready_q  <= s_ready_d;
            done_irq_q <= done_irq_d;
            done_q     <= done_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            outcnt_q   <= outcnt_d;
            amt_q      <= amt_d;
            sr_q       <= sr_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign s_ready   = s_ready_q;
    assign m_valid   = sr_q[LATENCY-1];
    assign run       = run_q;
    assign amounts   = amt_q;
    assign done_irq  = done_irq_q;

endmodule

// File: tb/tb_dorow_job_ctrl.sv
// Bench for dorow_job_ctrl: directed and randomized jobs checked against a schedule model
// derived from accept positions (result = accept + LATENCY).
module tb_dorow_job_ctrl;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned LEN_W   = 16;

    logic clk = 1'b0;
    logic rst;
    logic s_valid, s_ready, m_valid, run, done_irq;
    logic [47:0] amounts;
    logic [47:0] exp_amt;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dorow_job_ctrl_if #(.DATA_W(DATA_W)) bus ();

    dorow_job_ctrl #(
        .DATA_W (DATA_W),
        .LATENCY(LATENCY),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .run     (run),
        .amounts (amounts),
        .done_irq(done_irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Amount register image: six bits per buffer in the low bits of each byte.
    function automatic logic [23:0] pk(input logic [31:0] d);
        logic [23:0] r;
        for (int k = 0; k < 4; k++) r[6*k +: 6] = d[8*k +: 6];
        return r;
    endfunction

    function automatic bit has(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        bus.valid = 1'b1; bus.addr = a; bus.wstrb = '1; bus.wdata = d;
        @(negedge clk);
        chk("wr_ready", 64'(bus.ready), 64'd1);
        bus.valid = 1'b0; bus.wstrb = '0;
    endtask

    task automatic host_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        bus.valid = 1'b1; bus.addr = a; bus.wstrb = '0;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
        chk(tag, 64'(bus.rdata), 64'(exp));
        bus.valid = 1'b0;
    endtask

    // Cycle 0 carries the START write; run is cycle 1, s_ready opens at cycle 2.
    task automatic run_job(input int len, input bit pat[$], input bit mid_wr);
        int acc[$];
        int n = 0;
        int last, endc;
        logic exp_rdy;
        foreach (pat[i]) begin
            if (n < len && pat[i]) begin
                acc.push_back(2 + i);
                n++;
            end
        end
        last = acc[acc.size()-1];
        endc = last + LATENCY + 1;
        bus.valid = 1'b1; bus.addr = 4'd0; bus.wstrb = '1; bus.wdata = 32'd1;
        for (int c = 1; c <= endc + 2; c++) begin
            exp_rdy = bus.valid;
            @(negedge clk);
            chk("ready", 64'(bus.ready), 64'(exp_rdy));
            bus.valid = 1'b0; bus.wstrb = '0;
            if (mid_wr && c == 3) begin
                bus.valid = 1'b1; bus.addr = 4'd4; bus.wstrb = '1; bus.wdata = 32'h3F3F3F3F;
            end
            if (mid_wr && c == 4) begin
                bus.valid = 1'b1; bus.addr = 4'd0; bus.wstrb = '1; bus.wdata = 32'd1;
            end
            chk("run", 64'(run), 64'(c == 1));
            chk("s_ready", 64'(s_ready), 64'(c >= 2 && c <= last));
            chk("m_valid", 64'(m_valid), 64'(has(acc, c - LATENCY)));
            chk("done_irq", 64'(done_irq), 64'(c == endc));
            chk("amounts", 64'(amounts), 64'(exp_amt));
            s_valid = (c >= 2 && c - 2 < pat.size()) ? pat[c-2] : 1'($urandom);
        end
        s_valid = 1'b0;
        host_read(4'd5, 32'(len), "outcnt");
        host_read(4'd1, 32'h2, "status_done");
    endtask

    initial begin
        bit p[$];
        logic [31:0] d;
        int len, ones;
        rst = 1'b1; s_valid = 1'b0;
        bus.valid = 1'b0; bus.addr = '0; bus.wstrb = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_run", 64'(run), 64'd0);
        chk("rst_irq", 64'(done_irq), 64'd0);
        chk("rst_amounts", 64'(amounts), 64'd0);
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        host_read(4'd1, 32'd0, "rst_status");
        host_read(4'd2, 32'd0, "rst_len");
        host_read(4'd3, 32'd0, "rst_amt_lo");
        @(negedge clk);
        chk("ready_idle", 64'(bus.ready), 64'd0);

        // Job 1: LEN=4, s_valid held high.
        exp_amt = 48'd0;
        host_write(4'd2, 32'd4);
        host_write(4'd3, 32'h03020100);
        exp_amt[23:0] = pk(32'h03020100);
        host_read(4'd3, 32'h03020100, "amt_lo");
        p = '{1, 1, 1, 1};
        run_job(4, p, 1'b0);

        // Job 2: LEN=3 with a bubble in the input.
        host_write(4'd2, 32'd3);
        p = '{1, 0, 1, 1};
        run_job(3, p, 1'b0);

        // Randomized jobs with fresh amounts.
        for (int j = 0; j < 5; j++) begin
            d = $urandom;
            host_write(4'd3, d);
            exp_amt[23:0] = pk(d);
            d = $urandom;
            host_write(4'd4, d);
            exp_amt[47:24] = pk(d);
            host_read(4'd4, d & 32'h3F3F3F3F, "amt_hi");
            len = $urandom_range(1, 6);
            host_write(4'd2, 32'(len));
            host_read(4'd2, 32'(len), "len");
            p = {};
            ones = 0;
            while (ones < len) begin
                p.push_back($urandom_range(0, 99) < 60);
                if (p[p.size()-1]) ones++;
            end
            run_job(len, p, 1'b0);
        end

        // AMT_HI write and START during FEED are both ignored.
        d = 32'h15152A2A;
        host_write(4'd4, d);
        exp_amt[47:24] = pk(d);
        host_write(4'd2, 32'd8);
        p = '{1, 1, 1, 1, 1, 1, 1, 1};
        run_job(8, p, 1'b1);
        host_read(4'd4, d, "amt_hi_kept");

        // ABORT after two accepts.
        bus.valid = 1'b1; bus.addr = 4'd0; bus.wstrb = '1; bus.wdata = 32'd1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.valid = 1'b0; bus.wstrb = '0;
            if (c == 3) begin
                bus.valid = 1'b1; bus.addr = 4'd0; bus.wstrb = '1; bus.wdata = 32'd2;
            end
            chk("ab_run", 64'(run), 64'(c == 1));
            chk("ab_s_ready", 64'(s_ready), 64'(c == 2 || c == 3));
            chk("ab_m_valid", 64'(m_valid), 64'd0);
            chk("ab_irq", 64'(done_irq), 64'd0);
            s_valid = 1'b1;
        end
        s_valid = 1'b0;
        host_read(4'd1, 32'd0, "ab_status");
        host_read(4'd5, 32'd0, "ab_outcnt");

        // ABORT and START together: nothing starts.
        host_write(4'd0, 32'd3);
        chk("abst_run", 64'(run), 64'd0);
        host_read(4'd1, 32'd0, "abst_status");

        // LEN=0: immediate done, single irq, no run.
        host_write(4'd2, 32'd0);
        host_write(4'd0, 32'd1);
        chk("len0_irq", 64'(done_irq), 64'd1);
        chk("len0_run", 64'(run), 64'd0);
        @(negedge clk);
        chk("len0_irq_once", 64'(done_irq), 64'd0);
        chk("len0_run2", 64'(run), 64'd0);
        host_read(4'd1, 32'h2, "len0_status");
        host_read(4'd7, 32'd0, "unmapped");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
